// File: rtl/wb_ctrl_pkg.sv
// ============================================================================
// Module : wb_ctrl_pkg
// Brief  : Writeback source codes, controller states and source helpers.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package wb_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_WRITE = 2'd2
  } wb_state_e;

  localparam logic [3:0] SRC_ALU   = 4'd0;
  localparam logic [3:0] SRC_MEM   = 4'd1;
  localparam logic [3:0] SRC_PC8   = 4'd2;
  localparam logic [3:0] SRC_SHIFT = 4'd3;
  localparam logic [3:0] SRC_HI    = 4'd4;
  localparam logic [3:0] SRC_LO    = 4'd5;
  localparam logic [3:0] SRC_LUI   = 4'd6;
  localparam logic [3:0] SRC_COP0  = 4'd7;
  localparam logic [3:0] SRC_SLT   = 4'd8;
  localparam logic [3:0] SRC_LINK  = 4'd9;
  localparam logic [3:0] SRC_MOVZ  = 4'd10;
  localparam logic [3:0] SRC_LAST  = SRC_MOVZ;

  function automatic logic src_legal(input logic [3:0] src);
    return src <= SRC_LAST;
  endfunction

  // Sources whose data arrives later and must be waited for.
  function automatic logic src_needs_ready(input logic [3:0] src);
    return (src == SRC_MEM) || (src == SRC_SHIFT) ||
           (src == SRC_HI)  || (src == SRC_LO);
  endfunction

  function automatic logic src_ready(input logic [3:0] src,
                                     input logic       mem_ready,
                                     input logic       shift_done,
                                     input logic       hilo_done);
    logic rdy;
    rdy = 1'b0;
    case (src)
      SRC_MEM:        rdy = mem_ready;
      SRC_SHIFT:      rdy = shift_done;
      SRC_HI, SRC_LO: rdy = hilo_done;
      default:        rdy = 1'b0;
    endcase
    return rdy;
  endfunction

endpackage

`default_nettype wire

// File: rtl/wb_timer.sv
// ============================================================================
// Module : wb_timer
// Brief  : Wait-cycle counter; flags the last allowed cycle of a WAIT.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module wb_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [4:0] TMO_LAST = 5'(TIMEOUT - 1);

  logic [4:0] count_q;
  logic [4:0] count_d;

  // Counter restarts from zero each time WAIT is entered.
  assign count_d   = en_i ? count_q + 5'd1 : 5'd0;
  assign expired_o = en_i && (count_q == TMO_LAST);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) count_q <= 5'd0;
    else         count_q <= count_d;
  end

endmodule

`default_nettype wire

// File: rtl/wb_ctrl.sv
// ============================================================================
// Module : wb_ctrl
// Brief  : Writeback controller: selects source, waits for ready, writes RF.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module wb_ctrl
  import wb_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       wb_req_i,
  input  logic [3:0] wb_src_i,
  input  logic [4:0] wb_dst_i,
  input  logic       mem_ready_i,
  input  logic       shift_done_i,
  input  logic       hilo_done_i,
  input  logic       abort_i,
  output logic [3:0] mem_to_reg_o,
  output logic       reg_write_o,
  output logic [4:0] write_reg_o,
  output logic       wb_busy_o,
  output logic       wb_done_o,
  output logic       wb_err_o
);

  wb_state_e  state_q, state_d;
  logic [3:0] src_q, src_d;
  logic [4:0] dst_q, dst_d;
  logic [3:0] m2r_q, m2r_d;
  logic [4:0] wr_q, wr_d;
  logic       reg_write_q, reg_write_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic       expired;

  wb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .en_i      (state_q == ST_WAIT),
    .expired_o (expired)
  );

  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    dst_d       = dst_q;
    reg_write_d = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (wb_req_i) begin
          src_d = wb_src_i;
          dst_d = wb_dst_i;
          if (!src_legal(wb_src_i))          err_d   = 1'b1;
          else if (src_needs_ready(wb_src_i)) state_d = ST_WAIT;
          else                                state_d = ST_WRITE;
        end
      end
      // Abort outranks both the ready strobe and the timeout.
      ST_WAIT: begin
        if (abort_i) begin
          state_d = ST_IDLE;
        end else if (src_ready(src_q, mem_ready_i, shift_done_i, hilo_done_i)) begin
          state_d = ST_WRITE;
        end else if (expired) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end
      end
      ST_WRITE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // Outputs are registered from the next state so they align with it.
    if (state_d == ST_WRITE) begin
      reg_write_d = (dst_d != 5'd0);
      done_d      = 1'b1;
    end
    busy_d = (state_d != ST_IDLE);
    m2r_d  = busy_d ? src_d : 4'd0;
    wr_d   = busy_d ? dst_d : 5'd0;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      src_q       <= 4'd0;
      dst_q       <= 5'd0;
      m2r_q       <= 4'd0;
      wr_q        <= 5'd0;
      reg_write_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      m2r_q       <= m2r_d;
      wr_q        <= wr_d;
      reg_write_q <= reg_write_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign mem_to_reg_o = m2r_q;
  assign write_reg_o  = wr_q;
  assign reg_write_o  = reg_write_q;
  assign wb_busy_o    = busy_q;
  assign wb_done_o    = done_q;
  assign wb_err_o     = err_q;

endmodule

`default_nettype wire

// File: tb/tb_wb_ctrl.sv
// ============================================================================
// Module : tb_wb_ctrl
// Brief  : Directed self-checking bench for wb_ctrl.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_wb_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wb_req = 1'b0;
  logic [3:0] wb_src = 4'd0;
  logic [4:0] wb_dst = 5'd0;
  logic       mem_ready = 1'b0;
  logic       shift_done = 1'b0;
  logic       hilo_done = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] mem_to_reg;
  logic       reg_write;
  logic [4:0] write_reg;
  logic       wb_busy;
  logic       wb_done;
  logic       wb_err;

  int checks = 0;
  int errors = 0;

  wb_ctrl #(.TIMEOUT(16)) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .wb_req_i     (wb_req),
    .wb_src_i     (wb_src),
    .wb_dst_i     (wb_dst),
    .mem_ready_i  (mem_ready),
    .shift_done_i (shift_done),
    .hilo_done_i  (hilo_done),
    .abort_i      (abort),
    .mem_to_reg_o (mem_to_reg),
    .reg_write_o  (reg_write),
    .write_reg_o  (write_reg),
    .wb_busy_o    (wb_busy),
    .wb_done_o    (wb_done),
    .wb_err_o     (wb_err)
  );

  always #5 clk = ~clk;

  // Packed order: busy, done, err, reg_write, mem_to_reg[3:0], write_reg[4:0]
  function automatic logic [12:0] pk(input logic b, input logic d, input logic e,
                                     input logic rw, input logic [3:0] m,
                                     input logic [4:0] w);
    return {b, d, e, rw, m, w};
  endfunction

  localparam logic [12:0] IDLE_OUT = 13'd0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [12:0] exp);
    logic [12:0] act;
    act = {wb_busy, wb_done, wb_err, reg_write, mem_to_reg, write_reg};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got busy/done/err/rw/m2r/wr=%b required %b", name, act, exp);
    end
  endtask

  task automatic request(input logic [3:0] s, input logic [4:0] d);
    wb_req = 1'b1;
    wb_src = s;
    wb_dst = d;
    tick();
    wb_req = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  src;
    logic [4:0]  dst;
    logic [12:0] exp;
  } vec_t;

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{4'd8,  5'd9,  pk(1, 1, 0, 1, 4'd8,  5'd9)};
    vecs[1]  = '{4'd0,  5'd0,  pk(1, 1, 0, 0, 4'd0,  5'd0)};
    vecs[2]  = '{4'd2,  5'd31, pk(1, 1, 0, 1, 4'd2,  5'd31)};
    vecs[3]  = '{4'd10, 5'd1,  pk(1, 1, 0, 1, 4'd10, 5'd1)};
    vecs[4]  = '{4'd6,  5'd17, pk(1, 1, 0, 1, 4'd6,  5'd17)};
    vecs[5]  = '{4'd12, 5'd5,  pk(0, 0, 1, 0, 4'd0,  5'd0)};
    vecs[6]  = '{4'd11, 5'd3,  pk(0, 0, 1, 0, 4'd0,  5'd0)};
    vecs[7]  = '{4'd15, 5'd0,  pk(0, 0, 1, 0, 4'd0,  5'd0)};
    vecs[8]  = '{4'd1,  5'd4,  pk(1, 0, 0, 0, 4'd1,  5'd4)};
    vecs[9]  = '{4'd3,  5'd12, pk(1, 0, 0, 0, 4'd3,  5'd12)};
    vecs[10] = '{4'd4,  5'd20, pk(1, 0, 0, 0, 4'd4,  5'd20)};
    vecs[11] = '{4'd5,  5'd6,  pk(1, 0, 0, 0, 4'd5,  5'd6)};

    #1;
    chk("reset_async", IDLE_OUT);
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("idle_after_reset", IDLE_OUT);

    // One request per vector, then return to IDLE (abort if waiting).
    for (int i = 0; i < 12; i++) begin
      request(vecs[i].src, vecs[i].dst);
      chk($sformatf("vec%0d_src%0d", i, vecs[i].src), vecs[i].exp);
      if (vecs[i].exp[12] && !vecs[i].exp[11]) abort = 1'b1;
      tick();
      abort = 1'b0;
      chk($sformatf("vec%0d_idle", i), IDLE_OUT);
    end

    // Load waits for mem_ready; foreign strobes ignored.
    request(4'd1, 5'd4);
    chk("mem_wait0", pk(1, 0, 0, 0, 4'd1, 5'd4));
    shift_done = 1'b1; hilo_done = 1'b1;
    tick();
    shift_done = 1'b0; hilo_done = 1'b0;
    chk("mem_wait1_foreign", pk(1, 0, 0, 0, 4'd1, 5'd4));
    tick();
    chk("mem_wait2", pk(1, 0, 0, 0, 4'd1, 5'd4));
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk("mem_write", pk(1, 1, 0, 1, 4'd1, 5'd4));
    tick();
    chk("mem_idle", IDLE_OUT);

    // HI/LO timeout: 16 WAIT cycles, then an error pulse.
    request(4'd4, 5'd7);
    chk("tmo_wait_first", pk(1, 0, 0, 0, 4'd4, 5'd7));
    for (int i = 0; i < 15; i++) tick();
    chk("tmo_wait_last", pk(1, 0, 0, 0, 4'd4, 5'd7));
    tick();
    chk("tmo_err", pk(0, 0, 1, 0, 4'd0, 5'd0));
    tick();
    chk("tmo_idle", IDLE_OUT);

    // Abort beats a simultaneous shift_done.
    request(4'd3, 5'd5);
    tick();
    shift_done = 1'b1; abort = 1'b1;
    tick();
    shift_done = 1'b0; abort = 1'b0;
    chk("abort_vs_ready", IDLE_OUT);
    tick();
    chk("abort_idle", IDLE_OUT);

    // Requests while busy and in the WRITE cycle are dropped.
    request(4'd1, 5'd2);
    wb_req = 1'b1; wb_src = 4'd8; wb_dst = 5'd9;
    tick();
    chk("busy_req_ignored", pk(1, 0, 0, 0, 4'd1, 5'd2));
    wb_req = 1'b0;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk("busy_write", pk(1, 1, 0, 1, 4'd1, 5'd2));
    wb_req = 1'b1;
    tick();
    chk("write_cycle_req_ignored", IDLE_OUT);
    tick();
    wb_req = 1'b0;
    chk("req_after_write", pk(1, 1, 0, 1, 4'd8, 5'd9));
    tick();
    chk("req_after_write_idle", IDLE_OUT);

    // Asynchronous reset mid-WAIT clears outputs at once; no later write.
    request(4'd5, 5'd3);
    tick();
    chk("pre_reset_wait", pk(1, 0, 0, 0, 4'd5, 5'd3));
    reset = 1'b1;
    #1;
    chk("reset_mid_wait", IDLE_OUT);
    tick();
    reset = 1'b0;
    hilo_done = 1'b1;
    tick();
    hilo_done = 1'b0;
    chk("no_write_after_reset", IDLE_OUT);
    tick();
    chk("idle_final", IDLE_OUT);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
